// File: rtl/axi_memory_responder_if.sv
// AXI channel bundles for the on-chip memory responder.
// One interface per channel; the responder binds the slave side.
interface axi_aw_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            awid;
  logic [3:0]            awlen;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  modport slave (
    input  awid, awlen, awaddr, awvalid,
    output awready
  );
  modport master (
    output awid, awlen, awaddr, awvalid,
    input  awready
  );
endinterface

interface axi_w_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            wid;
  logic                  wlast;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  modport slave (
    input  wid, wlast, wdata, wvalid,
    output wready
  );
  modport master (
    output wid, wlast, wdata, wvalid,
    input  wready
  );
endinterface

interface axi_b_if;
  logic [3:0] bid;
  logic       bvalid;
  logic       bready;
  modport slave (
    output bid, bvalid,
    input  bready
  );
  modport master (
    input  bid, bvalid,
    output bready
  );
endinterface

interface axi_ar_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            arid;
  logic [3:0]            arlen;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  modport slave (
    input  arid, arlen, araddr, arvalid,
    output arready
  );
  modport master (
    output arid, arlen, araddr, arvalid,
    input  arready
  );
endinterface

interface axi_r_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            rid;
  logic                  rlast;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;
  modport slave (
    output rid, rlast, rdata, rvalid,
    input  rready
  );
  modport master (
    input  rid, rlast, rdata, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_memory_responder.sv
// AXI slave backed by an on-chip word memory.
// Independent read and write FSMs, one transaction each.
module axi_memory_responder #(
  parameter int    DEPTH        = 16384,
  parameter int    READ_LATENCY = 4,
  parameter string INIT_FILE    = "",
  parameter int    ADDR_WIDTH   = 32,
  parameter int    DATA_WIDTH   = 32
) (
  input logic     clk,
  input logic     rst_n,
  axi_aw_if.slave axi_write_address,
  axi_w_if.slave  axi_write_data,
  axi_b_if.slave  axi_write_response,
  axi_ar_if.slave axi_read_address,
  axi_r_if.slave  axi_read_data
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = 4;
  localparam logic [LW-1:0] WAIT_INIT =
    LW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            r_state;
  logic [3:0]            r_id;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_nxt;
  logic [2:0]            r_len;
  logic [2:0]            r_beat;
  logic [LW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data;

  logic [1:0]            w_state;
  logic [3:0]            w_id;
  logic [3:0]            w_len;
  logic [IW-1:0]         w_ptr;

  logic r_idle, r_wait, r_burst;
  logic w_idle, w_data, w_resp;
  logic ar_rdy, aw_rdy, w_rdy;
  logic r_vld, b_vld, r_last;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [IW-1:0] ar_idx;
  logic [IW-1:0] aw_idx;

  assign r_idle  = (r_state == R_IDLE);
  assign r_wait  = (r_state == R_WAIT);
  assign r_burst = (r_state == R_BURST);
  assign w_idle  = (w_state == W_IDLE);
  assign w_data  = (w_state == W_DATA);
  assign w_resp  = (w_state == W_RESP);

  // Reset forces every handshake output low in the same cycle.
  assign ar_rdy = rst_n & r_idle;
  assign r_vld  = rst_n & r_burst;
  assign aw_rdy = rst_n & w_idle;
  assign w_rdy  = rst_n & w_data;
  assign b_vld  = rst_n & w_resp;
  assign r_last = (r_beat == r_len);

  assign ar_hs = ar_rdy & axi_read_address.arvalid;
  assign r_hs  = r_vld  & axi_read_data.rready;
  assign aw_hs = aw_rdy & axi_write_address.awvalid;
  assign w_hs  = w_rdy  & axi_write_data.wvalid;
  assign b_hs  = b_vld  & axi_write_response.bready;

  assign ar_idx = axi_read_address.araddr[IW-1:0];
  assign aw_idx = axi_write_address.awaddr[IW-1:0];
  assign r_nxt  = r_ptr + 1'b1;

  assign axi_read_address.arready  = ar_rdy;
  assign axi_read_data.rvalid      = r_vld;
  assign axi_read_data.rlast       = r_vld & r_last;
  assign axi_read_data.rid         = rst_n ? r_id : 4'd0;
  assign axi_read_data.rdata       = r_data;
  assign axi_write_address.awready = aw_rdy;
  assign axi_write_data.wready     = w_rdy;
  assign axi_write_response.bvalid = b_vld;
  assign axi_write_response.bid    = rst_n ? w_id : 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_ptr   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      unique case (1'b1)
        r_idle: begin
          if (ar_hs) begin
            r_id   <= axi_read_address.arid;
            r_ptr  <= ar_idx;
            r_len  <= axi_read_address.arlen[2:0];
            r_beat <= '0;
            r_cnt  <= WAIT_INIT;
            if (READ_LATENCY == 1) begin
              r_state <= R_BURST;
              r_data  <= mem[ar_idx];
            end else begin
              r_state <= R_WAIT;
            end
          end
        end
        r_wait: begin
          if (r_cnt == '0) begin
            r_state <= R_BURST;
            r_data  <= mem[r_ptr];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        r_burst: begin
          if (r_hs) begin
            if (r_last) begin
              r_state <= R_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_ptr  <= r_nxt;
              r_data <= mem[r_nxt];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_len   <= '0;
      w_ptr   <= '0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          if (aw_hs) begin
            w_id    <= axi_write_address.awid;
            w_len   <= axi_write_address.awlen;
            w_ptr   <= aw_idx;
            w_state <= W_DATA;
          end
        end
        w_data: begin
          if (w_hs) begin
            w_ptr <= w_ptr + 1'b1;
            if (axi_write_data.wlast) w_state <= W_RESP;
          end
        end
        w_resp: begin
          if (b_hs) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_hs) mem[w_ptr] <= axi_write_data.wdata;
  end

  // WLAST, not AWLEN, ends a burst; the unrouted fields end here.
  logic unused_fields;
  assign unused_fields = ^{w_len,
                           axi_read_address.arlen[3],
                           axi_read_address.araddr,
                           axi_write_address.awaddr,
                           axi_write_data.wid};

endmodule

// File: tb/tb_axi_memory_responder.sv
// Directed plus randomized bench for axi_memory_responder.
// A word-array model predicts every read beat.
module tb_axi_memory_responder;
  localparam int DEPTH = 16384;
  localparam int LAT   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [DEPTH];

  axi_aw_if #(.ADDR_WIDTH(AW)) aw_bus ();
  axi_w_if  #(.DATA_WIDTH(DW)) w_bus ();
  axi_b_if                     b_bus ();
  axi_ar_if #(.ADDR_WIDTH(AW)) ar_bus ();
  axi_r_if  #(.DATA_WIDTH(DW)) r_bus ();

  axi_memory_responder #(
    .DEPTH(DEPTH),
    .READ_LATENCY(LAT),
    .INIT_FILE(""),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axi_write_address(aw_bus),
    .axi_write_data(w_bus),
    .axi_write_response(b_bus),
    .axi_read_address(ar_bus),
    .axi_read_data(r_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int midx(input logic [AW-1:0] a, input int k);
    logic [AW-1:0] s;
    s = a + AW'(k);
    return int'(s % AW'(DEPTH));
  endfunction

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet();
    check("rst_arready", ar_bus.arready, 0);
    check("rst_awready", aw_bus.awready, 0);
    check("rst_wready", w_bus.wready, 0);
    check("rst_rvalid", r_bus.rvalid, 0);
    check("rst_bvalid", b_bus.bvalid, 0);
    check("rst_rlast", r_bus.rlast, 0);
    check("rst_rid", r_bus.rid, 0);
    check("rst_bid", b_bus.bid, 0);
  endtask

  task automatic write_burst(input logic [3:0] id,
                             input logic [AW-1:0] addr,
                             input int n,
                             input bit rnd,
                             input logic [DW-1:0] d0,
                             input int bstall);
    logic [DW-1:0] d;
    int guard;
    aw_bus.awid    = id;
    aw_bus.awlen   = 4'(n - 1);
    aw_bus.awaddr  = addr;
    aw_bus.awvalid = 1'b1;
    guard = 0;
    while (!aw_bus.awready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("aw_ready", aw_bus.awready, 1);
    @(negedge clk);
    aw_bus.awvalid = 1'b0;
    for (int k = 0; k < n; k++) begin
      d = rnd ? DW'($urandom) : d0 + DW'(k);
      w_bus.wid    = id;
      w_bus.wdata  = d;
      w_bus.wlast  = (k == n - 1);
      w_bus.wvalid = 1'b1;
      guard = 0;
      while (!w_bus.wready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("w_ready", w_bus.wready, 1);
      @(negedge clk);
      model[midx(addr, k)] = d;
    end
    w_bus.wvalid = 1'b0;
    w_bus.wlast  = 1'b0;
    check("b_valid", b_bus.bvalid, 1);
    check("b_id", b_bus.bid, id);
    for (int s = 0; s < bstall; s++) begin
      @(negedge clk);
      check("b_hold_valid", b_bus.bvalid, 1);
      check("b_hold_id", b_bus.bid, id);
      check("b_hold_awready", aw_bus.awready, 0);
      check("b_hold_wready", w_bus.wready, 0);
    end
    b_bus.bready = 1'b1;
    @(negedge clk);
    b_bus.bready = 1'b0;
    check("b_done_valid", b_bus.bvalid, 0);
    check("b_done_awready", aw_bus.awready, 1);
  endtask

  task automatic read_burst(input logic [3:0] id,
                            input logic [AW-1:0] addr,
                            input logic [3:0] len,
                            input int stall);
    int n, lat, guard;
    logic [DW-1:0] exp;
    logic last;
    n = int'(len[2:0]) + 1;
    ar_bus.arid    = id;
    ar_bus.arlen   = len;
    ar_bus.araddr  = addr;
    ar_bus.arvalid = 1'b1;
    guard = 0;
    while (!ar_bus.arready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ar_ready", ar_bus.arready, 1);
    @(negedge clk);
    ar_bus.arvalid = 1'b0;
    lat = 1;
    while (!r_bus.rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("r_latency", lat, LAT);
    for (int k = 0; k < n; k++) begin
      exp  = model[midx(addr, k)];
      last = (k == n - 1);
      for (int s = 0; s < stall; s++) begin
        r_bus.rready = 1'b0;
        check("r_stall_valid", r_bus.rvalid, 1);
        check("r_stall_data", r_bus.rdata, exp);
        check("r_stall_id", r_bus.rid, id);
        check("r_stall_last", r_bus.rlast, last);
        @(negedge clk);
      end
      r_bus.rready = 1'b1;
      check("r_valid", r_bus.rvalid, 1);
      check("r_data", r_bus.rdata, exp);
      check("r_id", r_bus.rid, id);
      check("r_last", r_bus.rlast, last);
      @(negedge clk);
    end
    r_bus.rready = 1'b0;
    check("r_done_valid", r_bus.rvalid, 0);
    check("r_done_arready", ar_bus.arready, 1);
  endtask

  initial begin
    logic [AW-1:0] x;
    logic [AW-1:0] base;
    logic [DW-1:0] old;
    logic [3:0] rl;
    logic [3:0] rid;
    int n;

    aw_bus.awid = '0; aw_bus.awlen = '0; aw_bus.awaddr = '0;
    w_bus.wid = '0; w_bus.wdata = '0; w_bus.wlast = 1'b0;
    w_bus.wvalid = 1'b0; b_bus.bready = 1'b0;
    ar_bus.arid = '0; ar_bus.arlen = '0; ar_bus.araddr = '0;
    r_bus.rready = 1'b0;
    ar_bus.arvalid = 1'b1;
    aw_bus.awvalid = 1'b1;
    rst_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check_quiet();
    end
    rst_n = 1'b1;
    ar_bus.arvalid = 1'b0;
    aw_bus.awvalid = 1'b0;
    #1;
    check("rel_arready", ar_bus.arready, 1);
    check("rel_awready", aw_bus.awready, 1);
    check("rel_wready", w_bus.wready, 0);
    check("rel_rdata", r_bus.rdata, 0);
    @(negedge clk);

    write_burst(4'd0, 32'h100, 8, 1'b0, 32'hA0, 0);
    read_burst(4'd1, 32'h100, 4'd7, 0);

    write_burst(4'd9, 32'h400, 4, 1'b1, '0, 5);
    read_burst(4'd10, 32'h400, 4'd3, 2);

    write_burst(4'd3, 32'h3FFE, 4, 1'b1, '0, 0);
    read_burst(4'd4, 32'h3FFE, 4'd3, 0);
    read_burst(4'd5, 32'h0000, 4'd1, 1);

    read_burst(4'd2, 32'h0001_0100, 4'hF, 0);

    write_burst(4'd7, 32'h300, 10, 1'b1, '0, 0);
    read_burst(4'd8, 32'h300, 4'd7, 0);
    read_burst(4'd8, 32'h308, 4'd1, 0);

    // Write commits on the same edge the read beat loads.
    x = 32'h200;
    write_burst(4'd2, x, 1, 1'b0, 32'h1234_5678, 0);
    old = model[midx(x, 0)];
    aw_bus.awid = 4'd6; aw_bus.awlen = 4'd0;
    aw_bus.awaddr = x; aw_bus.awvalid = 1'b1;
    @(negedge clk);
    aw_bus.awvalid = 1'b0;
    check("col_wready", w_bus.wready, 1);
    ar_bus.arid = 4'd3; ar_bus.arlen = 4'd0;
    ar_bus.araddr = x; ar_bus.arvalid = 1'b1;
    check("col_arready", ar_bus.arready, 1);
    @(negedge clk);
    ar_bus.arvalid = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    w_bus.wdata = 32'h55; w_bus.wlast = 1'b1; w_bus.wvalid = 1'b1;
    @(negedge clk);
    w_bus.wvalid = 1'b0; w_bus.wlast = 1'b0;
    check("col_rvalid", r_bus.rvalid, 1);
    check("col_old_data", r_bus.rdata, old);
    check("col_rlast", r_bus.rlast, 1);
    check("col_bvalid", b_bus.bvalid, 1);
    check("col_bid", b_bus.bid, 6);
    model[midx(x, 0)] = 32'h55;
    r_bus.rready = 1'b1; b_bus.bready = 1'b1;
    @(negedge clk);
    r_bus.rready = 1'b0; b_bus.bready = 1'b0;
    check("col_arready_after", ar_bus.arready, 1);
    check("col_awready_after", aw_bus.awready, 1);
    read_burst(4'd4, x, 4'd0, 0);

    // Reset lands while beat 3 of 8 is presented.
    ar_bus.arid = 4'd5; ar_bus.arlen = 4'd7;
    ar_bus.araddr = 32'h100; ar_bus.arvalid = 1'b1;
    @(negedge clk);
    ar_bus.arvalid = 1'b0;
    n = 1;
    while (!r_bus.rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_latency", n, LAT);
    r_bus.rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("mid_data", r_bus.rdata, model[midx(32'h100, k)]);
      @(negedge clk);
    end
    check("mid_beat3", r_bus.rdata, model[midx(32'h100, 2)]);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rvalid", r_bus.rvalid, 0);
    check("mid_arready", ar_bus.arready, 0);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("mid_no_beat", r_bus.rvalid, 0);
    end
    r_bus.rready = 1'b0;
    check("mid_rdata_clr", r_bus.rdata, 0);
    read_burst(4'd6, 32'h100, 4'd7, 1);

    for (int it = 0; it < 8; it++) begin
      base = AW'($urandom_range(0, DEPTH - 1));
      n    = int'($urandom_range(1, 8));
      rid  = 4'($urandom);
      write_burst(rid, base | (AW'($urandom_range(0, 255)) << 14),
                  n, 1'b1, '0, int'($urandom_range(0, 2)));
      rl    = 4'(n - 1);
      rl[3] = 1'($urandom_range(0, 1));
      read_burst(rid + 4'd1, base, rl, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
